// File: rtl/cic_comp_fir.sv
// Compensation FIR behind the CIC decimator: circular delay line, one shared
// multiplier time-multiplexed over NTAPS clocks, then round, saturate and strobe out.
module cic_comp_fir #(
  parameter int IN_W   = 19,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 15,
  parameter logic [NTAPS*COEF_W-1:0] COEFFS = {{((NTAPS-1)*COEF_W){1'b0}}, COEF_W'(16384)},
  parameter int SHIFT  = 14,
  parameter int OUT_W  = 24
) (
  input  logic                    clk,
  input  logic                    i_reset_n,
  input  logic                    i_valid,
  input  logic signed [IN_W-1:0]  i_data,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam int ACC_W = IN_W + COEF_W + $clog2(NTAPS);
  localparam int IDX_W = $clog2(NTAPS);
  localparam int P_W   = IN_W + COEF_W;
  // Rounding/saturation width: wide enough for acc plus round bias and for the clamp limits.
  localparam int R_W   = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;

  localparam logic signed [R_W-1:0] HALF =
    (SHIFT > 0) ? (R_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [R_W-1:0] MAXV = (R_W'(1) << (OUT_W - 1)) - R_W'(1);
  localparam logic signed [R_W-1:0] MINV = ~MAXV;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic signed [IN_W-1:0]   dline [NTAPS];
  logic [IDX_W-1:0]         wp;
  logic [IDX_W-1:0]         rp;
  logic [IDX_W-1:0]         k;
  logic signed [ACC_W-1:0]  acc;

  logic signed [COEF_W-1:0] coef;
  logic signed [P_W-1:0]    prod;
  logic signed [R_W-1:0]    rnd;
  logic signed [R_W-1:0]    shifted;
  logic signed [OUT_W-1:0]  sat_val;

  always_comb begin
    coef    = COEFFS[int'(k)*COEF_W +: COEF_W];
    prod    = dline[rp] * coef;
    rnd     = R_W'(acc) + HALF;
    shifted = rnd >>> SHIFT;
    if (shifted > MAXV)
      sat_val = MAXV[OUT_W-1:0];
    else if (shifted < MINV)
      sat_val = MINV[OUT_W-1:0];
    else
      sat_val = shifted[OUT_W-1:0];
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      k         <= '0;
      acc       <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_overrun <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) dline[i] <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_valid && state != IDLE) o_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (i_valid) begin
            dline[wp] <= i_data;
            rp        <= wp;
            acc       <= '0;
            k         <= '0;
            state     <= MAC;
          end
        end
        MAC: begin
          // rp walks backwards from the newest sample, so tap k reads x[n-k].
          acc <= acc + ACC_W'(prod);
          rp  <= (rp == '0) ? LAST : rp - 1'b1;
          if (k == LAST) state <= OUT;
          else           k     <= k + 1'b1;
        end
        OUT: begin
          o_data  <= sat_val;
          o_valid <= 1'b1;
          wp      <= (wp == LAST) ? '0 : wp + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: four parameterisations share clock and reset; a behavioural
// convolution model feeds an expected-value queue that is drained as outputs appear.
module tb_cic_comp_fir;

  logic clk;
  logic rst_n;
  logic                valid [4];
  logic signed [18:0]  din   [4];
  logic                ov    [4];
  logic signed [23:0]  dout  [4];
  logic                busy  [4];
  logic                ovr   [4];

  int checks;
  int errors;

  longint exp_q[$];
  longint hist   [4][16];
  longint coef_c [4][16];
  int     ntaps_c [4];
  int     shift_c [4];

  cic_comp_fir u_def (
    .clk(clk), .i_reset_n(rst_n), .i_valid(valid[0]), .i_data(din[0]),
    .o_valid(ov[0]), .o_data(dout[0]), .o_busy(busy[0]), .o_overrun(ovr[0]));

  cic_comp_fir #(.NTAPS(4), .COEFFS(64'h0004_0003_0002_0001), .SHIFT(0)) u_t4 (
    .clk(clk), .i_reset_n(rst_n), .i_valid(valid[1]), .i_data(din[1]),
    .o_valid(ov[1]), .o_data(dout[1]), .o_busy(busy[1]), .o_overrun(ovr[1]));

  cic_comp_fir #(.NTAPS(2), .COEFFS(32'h0000_0001), .SHIFT(1)) u_rnd (
    .clk(clk), .i_reset_n(rst_n), .i_valid(valid[2]), .i_data(din[2]),
    .o_valid(ov[2]), .o_data(dout[2]), .o_busy(busy[2]), .o_overrun(ovr[2]));

  cic_comp_fir #(.NTAPS(2), .COEFFS(32'h7FFF_7FFF), .SHIFT(0), .OUT_W(24)) u_sat (
    .clk(clk), .i_reset_n(rst_n), .i_valid(valid[3]), .i_data(din[3]),
    .o_valid(ov[3]), .o_data(dout[3]), .o_busy(busy[3]), .o_overrun(ovr[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic longint model(input int d, input longint x);
    longint acc;
    longint r;
    for (int i = 15; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = x;
    acc = 0;
    for (int t = 0; t < ntaps_c[d]; t++) acc += hist[d][t] * coef_c[d][t];
    if (shift_c[d] > 0) r = (acc + (longint'(1) <<< (shift_c[d] - 1))) >>> shift_c[d];
    else                r = acc;
    if (r > 64'sd8388607)       r = 64'sd8388607;
    else if (r < -64'sd8388608) r = -64'sd8388608;
    return r;
  endfunction

  task automatic clear_hist();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 16; i++) hist[d][i] = 0;
  endtask

  task automatic wait_out(input int d, output int lat, output logic signed [23:0] val);
    lat = -1;
    val = '0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (ov[d]) begin
        lat = n;
        val = dout[d];
        break;
      end
    end
  endtask

  // Drive one sample (caller sits just after an edge), queue its model result,
  // wait for the output and hand back latency, observed and queued values.
  task automatic xfer(input int d, input longint x, output int lat,
                      output logic signed [23:0] val, output longint e);
    exp_q.push_back(model(d, x));
    valid[d] = 1'b1;
    din[d]   = 19'(x);
    @(posedge clk); #1;
    valid[d] = 1'b0;
    wait_out(d, lat, val);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 64'sh7fff_ffff_ffff;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || busy[d] !== 1'b0 || ovr[d] !== 1'b0 || dout[d] !== 24'sd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid=%b busy=%b overrun=%b data=%0d, required all 0",
                 d, ov[d], busy[d], ovr[d], dout[d]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    longint xs [2];
    int lat;
    logic signed [23:0] val;
    longint e;
    xs = '{-262144, 12345};
    for (int i = 0; i < 2; i++) begin
      xfer(0, xs[i], lat, val, e);
      checks++;
      if (lat !== 16) begin
        errors++;
        $display("FAIL identity_latency[%0d]: got %0d edges, required 16", i, lat);
      end
      checks++;
      if (val !== 24'(e) || longint'(val) != xs[i]) begin
        errors++;
        $display("FAIL identity_data[%0d]: got %0d, required %0d", i, val, xs[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b0) begin
        errors++;
        $display("FAIL identity_pulse[%0d]: o_valid=%b one cycle later, required 0", i, ov[0]);
      end
      gap(46);
    end
    checks++;
    if (ovr[0] !== 1'b0) begin
      errors++;
      $display("FAIL identity_overrun: got %b, required 0", ovr[0]);
    end
  endtask

  task automatic test_wrap();
    longint xs [5];
    longint req [5];
    int lat;
    logic signed [23:0] val;
    longint e;
    xs  = '{100, 0, 0, 0, 0};
    req = '{100, 200, 300, 400, 0};
    for (int i = 0; i < 5; i++) begin
      xfer(1, xs[i], lat, val, e);
      checks++;
      if (lat !== 5 || val !== 24'(e)) begin
        errors++;
        $display("FAIL wrap_sb[%0d]: got %0d after %0d edges, required %0d after 5", i, val, lat, e);
      end
      checks++;
      if (longint'(val) != req[i]) begin
        errors++;
        $display("FAIL wrap_const[%0d]: got %0d, required %0d", i, val, req[i]);
      end
      gap(3);
    end
  endtask

  task automatic test_rounding_back_to_back();
    longint xs [3];
    longint req [3];
    int lat;
    logic signed [23:0] val;
    longint e;
    xs  = '{3, -3, -4};
    req = '{2, -1, -2};
    // Each new strobe is driven in the cycle right after o_valid, i.e. straight out of OUT.
    for (int i = 0; i < 3; i++) begin
      xfer(2, xs[i], lat, val, e);
      checks++;
      if (lat !== 3 || val !== 24'(e) || longint'(val) != req[i]) begin
        errors++;
        $display("FAIL rounding[%0d]: got %0d after %0d edges, required %0d after 3",
                 i, val, lat, req[i]);
      end
    end
    checks++;
    if (ovr[2] !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_overrun: got %b, required 0", ovr[2]);
    end
    gap(4);
  endtask

  task automatic test_saturation();
    longint xs [4];
    longint req [4];
    int lat;
    logic signed [23:0] val;
    longint e;
    xs  = '{262143, 262143, -262144, -262144};
    req = '{8388607, 8388607, -32767, -8388608};
    for (int i = 0; i < 4; i++) begin
      xfer(3, xs[i], lat, val, e);
      checks++;
      if (lat !== 3 || val !== 24'(e) || longint'(val) != req[i]) begin
        errors++;
        $display("FAIL saturation[%0d]: got %0d after %0d edges, required %0d after 3",
                 i, val, lat, req[i]);
      end
      gap(4);
    end
  endtask

  task automatic test_overrun();
    int lat;
    int extra;
    logic signed [23:0] val;
    longint e;
    exp_q.push_back(model(0, 4321));
    valid[0] = 1'b1;
    din[0]   = 19'sd4321;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    valid[0] = 1'b1;
    din[0]   = -19'sd999;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    checks++;
    if (ovr[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b busy=%b, required 1 1", ovr[0], busy[0]);
    end
    wait_out(0, lat, val);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sh7fff_ffff_ffff;
    checks++;
    if (lat !== 11 || val !== 24'(e) || val !== 24'sd4321) begin
      errors++;
      $display("FAIL overrun_first: got %0d after %0d edges, required 4321 after 11", val, lat);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov[0]) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL overrun_single_output: got %0d extra strobes, required 0", extra);
    end
    xfer(0, -777, lat, val, e);
    checks++;
    if (lat !== 16 || val !== 24'(e) || val !== -24'sd777) begin
      errors++;
      $display("FAIL overrun_recover: got %0d after %0d edges, required -777 after 16", val, lat);
    end
    checks++;
    if (ovr[0] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b, required 1", ovr[0]);
    end
    gap(4);
  endtask

  task automatic test_random_history();
    int lat;
    logic signed [23:0] val;
    longint e;
    longint x;
    for (int i = 0; i < 10; i++) begin
      x = longint'($urandom_range(2000)) - 1000;
      xfer(1, x, lat, val, e);
      checks++;
      if (lat !== 5 || val !== 24'(e)) begin
        errors++;
        $display("FAIL history[%0d]: in %0d got %0d after %0d edges, required %0d after 5",
                 i, x, val, lat, e);
      end
      gap(2);
    end
  endtask

  task automatic test_reset_mid_mac();
    int lat;
    int stray;
    logic signed [23:0] val;
    longint e;
    valid[1] = 1'b1;
    din[1]   = 19'sd5;
    @(posedge clk); #1;
    valid[1] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL midmac_busy: got %b, required 1", busy[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov[1] !== 1'b0 || busy[1] !== 1'b0 || ovr[1] !== 1'b0 || dout[1] !== 24'sd0) begin
      errors++;
      $display("FAIL midmac_reset_outputs: valid=%b busy=%b overrun=%b data=%0d, required all 0",
               ov[1], busy[1], ovr[1], dout[1]);
    end
    clear_hist();
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov[1]) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL midmac_no_output: got %0d strobes, required 0", stray);
    end
    xfer(1, 7, lat, val, e);
    checks++;
    if (lat !== 5 || val !== 24'(e) || val !== 24'sd7) begin
      errors++;
      $display("FAIL midmac_history_cleared: got %0d after %0d edges, required 7 after 5", val, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int d = 0; d < 4; d++) begin
      valid[d] = 1'b0;
      din[d]   = '0;
    end
    ntaps_c = '{15, 4, 2, 2};
    shift_c = '{14, 0, 1, 0};
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 16; i++) coef_c[d][i] = 0;
    coef_c[0][0] = 16384;
    coef_c[1][0] = 1; coef_c[1][1] = 2; coef_c[1][2] = 3; coef_c[1][3] = 4;
    coef_c[2][0] = 1;
    coef_c[3][0] = 32767; coef_c[3][1] = 32767;
    clear_hist();

    test_reset();
    test_identity();
    test_wrap();
    test_rounding_back_to_back();
    test_saturation();
    test_overrun();
    test_random_history();
    test_reset_mid_mac();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
